// File: rtl/avalon_dmem_slave_if.sv
// Avalon-MM data-memory bus between the core's load/store unit (master) and avalon_dmem_slave.
// Request fields carry right-aligned data with lower-aligned byteenables.
interface avalon_dmem_slave_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 12
);
    logic [ADDRWIDTH-1:0] DMEM_Address_InBUS;
    logic [3:0]           DMEM_Byteenable_InBUS;
    logic                 DMEM_Read;
    logic                 DMEM_Write;
    logic [DATAWIDTH-1:0] DMEM_WriteData_InBUS;
    logic                 DMEM_Waitrequest;
    logic [DATAWIDTH-1:0] DMEM_ReadData_OutBUS;
    logic                 DMEM_ReadDataValid;
    logic [1:0]           DMEM_Response_OutBUS;
    logic                 DMEM_WriteResponseValid;

    modport master (
        output DMEM_Address_InBUS, DMEM_Byteenable_InBUS, DMEM_Read, DMEM_Write,
               DMEM_WriteData_InBUS,
        input  DMEM_Waitrequest, DMEM_ReadData_OutBUS, DMEM_ReadDataValid,
               DMEM_Response_OutBUS, DMEM_WriteResponseValid
    );

    modport slave (
        input  DMEM_Address_InBUS, DMEM_Byteenable_InBUS, DMEM_Read, DMEM_Write,
               DMEM_WriteData_InBUS,
        output DMEM_Waitrequest, DMEM_ReadData_OutBUS, DMEM_ReadDataValid,
               DMEM_Response_OutBUS, DMEM_WriteResponseValid
    );
endinterface

// File: rtl/avalon_dmem_slave.sv
// Avalon-MM data-memory responder: lane-steered byte/half/word access, one-cycle read latency.
// Optional DMEM_CLEAR_ON_RESET_EN: zero the whole RAM after reset before accepting requests.
module avalon_dmem_slave #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 12
) (
    input  logic               DMEM_CLOCK_50,
    input  logic               DMEM_RESET_InHigh,
    avalon_dmem_slave_if.slave bus
);
    localparam int IW    = ADDRWIDTH - 2;
    localparam int DEPTH = 1 << IW;

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    logic [3:0]           be_n;
    logic [1:0]           off;
    logic [IW-1:0]        addr_idx;
    logic                 misaligned;
    logic                 wait_w;
    logic                 rd_acc;
    logic                 wr_acc;

    logic                 wr_en;
    logic [IW-1:0]        wr_idx;
    logic [3:0]           wr_lanes;
    logic [DATAWIDTH-1:0] wr_data;

    logic [DATAWIDTH-1:0] rd_word_q;
    logic [1:0]           off_q;
    logic [3:0]           be_q;
    logic                 rvalid_q;
    logic                 wvalid_q;
    logic [1:0]           resp_q;
    logic [DATAWIDTH-1:0] rd_mask;
    logic [DATAWIDTH-1:0] rd_shift;

    // Unsupported byteenable patterns fall back to a full-word access.
    always_comb begin
        be_n = bus.DMEM_Byteenable_InBUS;
        if (be_n != 4'b0001 && be_n != 4'b0011)
            be_n = 4'b1111;
        off        = bus.DMEM_Address_InBUS[1:0];
        addr_idx   = bus.DMEM_Address_InBUS[ADDRWIDTH-1:2];
        misaligned = (be_n == 4'b0011 && off[0]) || (be_n == 4'b1111 && off != 2'd0);
    end

    assign wr_acc = bus.DMEM_Write & ~wait_w & ~DMEM_RESET_InHigh;
    assign rd_acc = bus.DMEM_Read & ~bus.DMEM_Write & ~wait_w & ~DMEM_RESET_InHigh;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]    state_q;
    logic [IW-1:0] clr_cnt_q;

    always_ff @(posedge DMEM_CLOCK_50) begin
        if (DMEM_RESET_InHigh) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == {IW{1'b1}})
                state_q <= ST_READY;
        end
    end

    assign wait_w = (state_q == ST_INIT) | DMEM_RESET_InHigh;

    // The clear sweep borrows the single write port; no requests are accepted meanwhile.
    always_comb begin
        wr_en    = wr_acc & ~misaligned;
        wr_idx   = addr_idx;
        wr_lanes = be_n << off;
        wr_data  = bus.DMEM_WriteData_InBUS << {off, 3'b000};
        if (state_q == ST_INIT) begin
            wr_en    = 1'b1;
            wr_idx   = clr_cnt_q;
            wr_lanes = 4'b1111;
            wr_data  = '0;
        end
    end
`else
    assign wait_w = 1'b0;

    always_comb begin
        wr_en    = wr_acc & ~misaligned;
        wr_idx   = addr_idx;
        wr_lanes = be_n << off;
        wr_data  = bus.DMEM_WriteData_InBUS << {off, 3'b000};
    end
`endif

    always_ff @(posedge DMEM_CLOCK_50) begin
        for (int i = 0; i < 4; i++)
            if (wr_en && wr_lanes[i])
                mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        if (rd_acc) begin
            rd_word_q <= mem_q[addr_idx];
            off_q     <= off;
            be_q      <= be_n;
        end
    end

    always_ff @(posedge DMEM_CLOCK_50) begin
        if (DMEM_RESET_InHigh) begin
            rvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
            resp_q   <= 2'b00;
        end else begin
            rvalid_q <= rd_acc;
            wvalid_q <= wr_acc;
            resp_q   <= ((rd_acc | wr_acc) && misaligned) ? 2'b10 : 2'b00;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign rd_mask[8*gi +: 8] = {8{be_q[gi]}};
    end

    assign rd_shift = rd_word_q >> {off_q, 3'b000};

    // Outputs read as reset values while reset is held so an in-flight response never escapes.
    assign bus.DMEM_Waitrequest        = wait_w;
    assign bus.DMEM_ReadDataValid      = rvalid_q & ~DMEM_RESET_InHigh;
    assign bus.DMEM_WriteResponseValid = wvalid_q & ~DMEM_RESET_InHigh;
    assign bus.DMEM_Response_OutBUS    = DMEM_RESET_InHigh ? 2'b00 : resp_q;
    assign bus.DMEM_ReadData_OutBUS    = (rvalid_q && !resp_q[1] && !DMEM_RESET_InHigh)
                                         ? (rd_shift & rd_mask) : '0;
endmodule

// File: doc/avalon_dmem_slave.md
# avalon_dmem_slave

Avalon-MM data-memory responder on the far side of the core's load/store byteenable interface. Accepts byte-addressed reads/writes carrying right-aligned data and lower-aligned byteenables (0001/0011/1111), steers lanes by address offset into a word-organised RAM, returns right-aligned read data with fixed one-cycle latency, and flags misaligned accesses with an error response.

## Interface
- DATAWIDTH, 32, data bus width; only 32 is supported.
- ADDRWIDTH, 12, byte-address width; depth = 2^(ADDRWIDTH-2) words.
- DMEM_CLOCK_50  in  1  system clock; all logic on the rising edge.
- DMEM_RESET_InHigh  in  1  synchronous, active-high reset.
- DMEM_Address_InBUS  in  ADDRWIDTH  byte address.
- DMEM_Byteenable_InBUS  in  4  lower-aligned enable: 0001 byte, 0011 half, 1111 word.
- DMEM_Read  in  1  read request.
- DMEM_Write  in  1  write request.
- DMEM_WriteData_InBUS  in  DATAWIDTH  right-aligned store data.
- DMEM_Waitrequest  out  1  request not accepted this cycle.
- DMEM_ReadData_OutBUS  out  DATAWIDTH  right-aligned read data, unused lanes zero.
- DMEM_ReadDataValid  out  1  read data/response valid.
- DMEM_Response_OutBUS  out  2  00 OKAY, 10 SLAVEERROR; qualified by ReadDataValid or WriteResponseValid.
- DMEM_WriteResponseValid  out  1  write response valid.

## Operation
- FSM states: INIT (only with DMEM_CLEAR_ON_RESET_EN), READY. Reset enters INIT if enabled, else READY.
- Accept: request accepted when (Read|Write) & ~Waitrequest. Waitrequest = 1 in INIT, 0 in READY.
- Read and Write both high in the same cycle: Write wins; no read response issued.
- Offset o = Address[1:0]. Misaligned: half with o=3 or odd o; word with o≠0. Byteenable values other than 0001/0011/1111 are treated as 1111.
- Aligned write: RAM word Address[ADDRWIDTH-1:2] lanes (Byteenable << o) written with (WriteData << 8·o); other lanes untouched.
- Misaligned write: RAM unchanged; response SLAVEERROR.
- Aligned read: fetch word, shift right by 8·o, mask to enabled width; response OKAY.
- Misaligned read: ReadData = 0, response SLAVEERROR.
- Back-to-back accepted requests every cycle are supported (fully pipelined, one stage).
- Write-then-read of same address in consecutive cycles returns the newly written data (write completes at the accept edge).

## Timing
- Reset values: Waitrequest = 1 if clear enabled else 0; ReadData = 0; ReadDataValid = 0; WriteResponseValid = 0; Response = 00.
- Read accepted at edge N -> ReadDataValid = 1 with data and response during cycle N+1, for exactly one cycle per accepted read.
- Write accepted at edge N -> RAM updated at edge N; WriteResponseValid = 1 during cycle N+1.
- Reset asserted mid-transaction: pending responses dropped; valids 0 the cycle after the reset edge; RAM contents preserved unless clear enabled.
- Clear counter: counts 0..depth-1, one word per cycle, wraps to READY after last word.

## Configuration
- DMEM_CLEAR_ON_RESET_EN defined: after reset, INIT zeroes all words, one per cycle, Waitrequest = 1 for exactly 2^(ADDRWIDTH-2) cycles, then READY; requests during INIT are stalled, not dropped.
- Not defined: no INIT state, Waitrequest tied 0, RAM contents undefined after power-up and retained across reset.

## Test plan
- Write 0xDEADBEEF, BE 1111, addr 0x10; read addr 0x10 BE 1111 -> ReadData 0xDEADBEEF one cycle after accept, response 00.
- Byte write 0x000000AA BE 0001 addr 0x12; read word addr 0x10 -> 0xDEAABEEF; byte read addr 0x12 -> 0x000000AA.
- Half write 0x00001234 BE 0011 addr 0x16 -> word 0x14 upper half 0x1234; half read addr 0x15 -> SLAVEERROR, data 0, RAM unchanged.
- Word read addr 0x11 -> SLAVEERROR with ReadDataValid; four consecutive reads at 0x0,0x4,0x8,0xC -> four consecutive valid cycles in order.
- With DMEM_CLEAR_ON_RESET_EN, ADDRWIDTH 6: reset, hold Read at 0x10 -> Waitrequest high 16 cycles, then accepted, data 0x00000000.
- Reset asserted the cycle after a read accept -> no ReadDataValid pulse; outputs at reset values.
